// File: rtl/interval_capture_counter.sv
// Measures the number of clk cycles between a rising edge on start and a
// rising edge on stop, with a saturating counter and sticky overflow flag.
module interval_capture_counter #(
    parameter int unsigned bits = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    output logic [bits-1:0] result,
    output logic            valid,
    output logic            overflow,
    output logic            busy
);

    localparam logic [bits-1:0] cnt_max = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic            start_q;
    logic            stop_q;
    logic            start_armed;
    logic            start_e;
    logic            stop_e;
    logic [bits-1:0] counter;
    logic [bits-1:0] counter_d;
    logic [bits-1:0] result_d;
    logic            valid_d;
    logic            overflow_d;

    // A start held high through reset release must be seen low before it counts.
    assign start_e = start & ~start_q & start_armed;
    assign stop_e  = stop & ~stop_q;

    // Edge-detect registers run every cycle, clear or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_q     <= start;
            stop_q      <= stop;
            start_armed <= start_armed | ~start;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start_e) state_d = RUN;
                RUN:        if (stop_e)  state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Datapath next values; result is the elapsed count including the stop edge.
    always_comb begin
        counter_d  = counter;
        result_d   = result;
        valid_d    = valid;
        overflow_d = overflow;
        if (clear) begin
            counter_d  = '0;
            result_d   = '0;
            valid_d    = 1'b0;
            overflow_d = 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start_e) begin
                        counter_d  = '0;
                        valid_d    = 1'b0;
                        overflow_d = 1'b0;
                    end
                end
                RUN: begin
                    if (counter != cnt_max) begin
                        counter_d = counter + bits'(1);
                        if (counter == cnt_max - bits'(1)) begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (stop_e) begin
                        result_d = (counter == cnt_max) ? cnt_max : counter + bits'(1);
                        valid_d  = 1'b1;
                    end
                end
                default: begin
                    counter_d = '0;
                end
            endcase
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= '0;
            result   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            counter  <= counter_d;
            result   <= result_d;
            valid    <= valid_d;
            overflow <= overflow_d;
            busy     <= (state_d == RUN);
        end
    end

endmodule
